// File: rtl/ha_array_pkg.sv
// Shared definitions for the half-adder-array accumulator.
// Holds the array geometry, the FSM state type, the row type and the
// helper that turns one (b,t) pair into its unweighted row value.
package ha_array_pkg;

  localparam int N_ARR = 4;   // arrays per operation, array k weighted 2^(2k)
  localparam int B_W   = 7;   // width of each ha_array_k_b bus
  localparam int T_W   = 9;   // width of each ha_array_k_t bus
  localparam int P_W   = 16;  // product width; accumulator is P_W+1 bits
  localparam int IDX_W = $clog2(N_ARR);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  typedef logic [T_W:0] row_t;

  // b[i] carries weight 2^(i+2) relative to t[i]; the largest row is
  // 511 + 4*127 = 1019, which fits the T_W+1 bit row exactly.
  function automatic row_t row_value(input logic [B_W-1:0] b,
                                     input logic [T_W-1:0] t);
    return row_t'(t) + (row_t'(b) << 2);
  endfunction

endpackage

// File: rtl/ha_row_weight.sv
// Combinational weighting of one half-adder array.
// Ports:
//   b    in  B_W      b bus of the selected array
//   t    in  T_W      t bus of the selected array
//   idx  in  IDX_W    array index k
//   term out P_W+1    (t + (b << 2)) << 2k
module ha_row_weight
  import ha_array_pkg::*;
(
  input  logic [B_W-1:0]   b,
  input  logic [T_W-1:0]   t,
  input  logic [IDX_W-1:0] idx,
  output logic [P_W:0]     term
);

  logic [P_W:0] row_ext;

  assign row_ext = (P_W+1)'(row_value(b, t));
  assign term    = row_ext << {idx, 1'b0};

endmodule

// File: rtl/ha_array_accumulator.sv
// Serial reduction of four half-adder-array row pairs into a 16-bit product.
// A bundle is captured in IDLE, one weighted array is added per cycle in
// ACC, and the result is held in DONE until the consumer takes it.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   bundle handshake (in_ready only in IDLE)
//   ha_array_k_b/_t       k=0..3 row pairs, sampled only on the accept cycle
//   out_valid / out_ready product handshake
//   product               accumulated sum modulo 2^16
//   ovf                   accumulated sum >= 2^16
module ha_array_accumulator
  import ha_array_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [B_W-1:0] ha_array_3_b,
  input  logic [T_W-1:0] ha_array_3_t,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           ovf
);

  state_t           state;
  logic [B_W-1:0]   b_in [N_ARR];
  logic [T_W-1:0]   t_in [N_ARR];
  logic [B_W-1:0]   b_q  [N_ARR];
  logic [T_W-1:0]   t_q  [N_ARR];
  logic [IDX_W-1:0] idx;
  logic [P_W:0]     acc;
  logic [P_W:0]     term;
  logic [P_W:0]     acc_sum;

  assign b_in[0] = ha_array_0_b;
  assign b_in[1] = ha_array_1_b;
  assign b_in[2] = ha_array_2_b;
  assign b_in[3] = ha_array_3_b;
  assign t_in[0] = ha_array_0_t;
  assign t_in[1] = ha_array_1_t;
  assign t_in[2] = ha_array_2_t;
  assign t_in[3] = ha_array_3_t;

  ha_row_weight u_row_weight (
    .b    (b_q[idx]),
    .t    (t_q[idx]),
    .idx  (idx),
    .term (term)
  );

  // Max sum is 1019*85 = 86615 < 2^17, so this never wraps.
  assign acc_sum = acc + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      for (int k = 0; k < N_ARR; k++) begin
        b_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // in_ready is registered high in IDLE, so in_valid alone is the accept.
          if (in_valid) begin
            for (int k = 0; k < N_ARR; k++) begin
              b_q[k] <= b_in[k];
              t_q[k] <= t_in[k];
            end
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          // Publish on the last add so out_valid rises with DONE.
          if (idx == IDX_W'(N_ARR - 1)) begin
            product   <= acc_sum[P_W-1:0];
            ovf       <= acc_sum[P_W];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
